// File: rtl/sobel_window_gen.sv
// 3x3 window generator feeding the sobel edge unit: two line buffers, window shift, request/response handshake.
// Optional ISSUE timeout with sticky sobel_err is enabled by defining SOBEL_WIN_TIMEOUT_EN.
module sobel_window_gen #(
  parameter int IMG_WIDTH = 16,
  parameter int PIX_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PIX_W-1:0]           pixel_in,
  input  logic                       pixel_valid,
  input  logic                       frame_start,
  output logic                       pixel_ready,
  output logic                       sobel_en,
  output logic [2:0][2:0][PIX_W-1:0] comp_matrix,
  input  logic                       sobel_done,
  input  logic                       output_pixel,
  output logic                       edge_valid,
  output logic                       edge_pixel
`ifdef SOBEL_WIN_TIMEOUT_EN
  ,
  output logic                       sobel_err
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]                      r_state;
  logic [IMG_WIDTH-1:0][PIX_W-1:0] r_lb0, r_lb1;
  logic [2:0][2:0][PIX_W-1:0]      r_win;
  logic [CW-1:0]                   r_col;
  logic [1:0]                      r_rows;
  logic                            r_edge_valid, r_edge_pixel;
`ifdef SOBEL_WIN_TIMEOUT_EN
  logic [3:0]                      r_tmo;
  logic                            r_err;
`endif

  logic          w_accept, w_last, w_complete;
  logic [CW-1:0] w_col_eff, w_col_nxt;
  logic [1:0]    w_rows_eff, w_rows_nxt;

  // frame_start re-bases the accepted pixel to (row 0, col 0) before any decision
  always_comb begin
    w_accept   = pixel_valid && (r_state == RUN);
    w_col_eff  = frame_start ? '0 : r_col;
    w_rows_eff = frame_start ? 2'd0 : r_rows;
    w_last     = (w_col_eff == CW'(IMG_WIDTH - 1));
    w_col_nxt  = w_last ? '0 : w_col_eff + CW'(1);
    w_rows_nxt = (w_last && (w_rows_eff != 2'd2)) ? w_rows_eff + 2'd1 : w_rows_eff;
    w_complete = (w_rows_eff == 2'd2) && (w_col_eff >= CW'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_lb0        <= '0;
      r_lb1        <= '0;
      r_win        <= '0;
      r_col        <= '0;
      r_rows       <= '0;
      r_edge_valid <= 1'b0;
      r_edge_pixel <= 1'b0;
`ifdef SOBEL_WIN_TIMEOUT_EN
      r_tmo        <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_edge_valid <= 1'b0;
      if (w_accept) begin
        r_lb0 <= {r_lb0[IMG_WIDTH-2:0], pixel_in};
        r_lb1 <= {r_lb1[IMG_WIDTH-2:0], r_lb0[IMG_WIDTH-1]};
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= r_lb1[IMG_WIDTH-1];
        r_win[1][2] <= r_lb0[IMG_WIDTH-1];
        r_win[2][2] <= pixel_in;
        r_col       <= w_col_nxt;
        r_rows      <= w_rows_nxt;
        if (w_complete) r_state <= ISSUE;
`ifdef SOBEL_WIN_TIMEOUT_EN
        r_tmo <= '0;
        if (frame_start) r_err <= 1'b0;
`endif
      end else if (r_state == ISSUE) begin
        if (sobel_done) begin
          r_edge_pixel <= output_pixel;
          r_edge_valid <= 1'b1;
          r_state      <= RUN;
        end
`ifdef SOBEL_WIN_TIMEOUT_EN
        else if (r_tmo == 4'hF) begin
          r_state <= RUN;
          r_err   <= 1'b1;
        end else begin
          r_tmo <= r_tmo + 4'd1;
        end
`else
        // without the timeout, ISSUE waits for sobel_done indefinitely
`endif
      end
    end
  end

  assign pixel_ready = (r_state == RUN);
  assign sobel_en    = (r_state == ISSUE);
  assign comp_matrix = r_win;
  assign edge_valid  = r_edge_valid;
  assign edge_pixel  = r_edge_pixel;
`ifdef SOBEL_WIN_TIMEOUT_EN
  assign sobel_err   = r_err;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen (IMG_WIDTH=4) with a latency-programmable sobel stub.
// Timeout checks follow SOBEL_WIN_TIMEOUT_EN when it is defined.
`timescale 1ns/1ps
module tb_sobel_window_gen;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       pixel_in = '0;
  logic             pixel_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             pixel_ready;
  logic             sobel_en;
  logic [2:0][2:0][7:0] comp_matrix;
  logic             sobel_done;
  logic             output_pixel = 1'b0;
  logic             edge_valid;
  logic             edge_pixel;
`ifdef SOBEL_WIN_TIMEOUT_EN
  logic             sobel_err;
`endif

  sobel_window_gen #(.IMG_WIDTH(W), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .frame_start(frame_start), .pixel_ready(pixel_ready), .sobel_en(sobel_en),
    .comp_matrix(comp_matrix), .sobel_done(sobel_done), .output_pixel(output_pixel),
    .edge_valid(edge_valid), .edge_pixel(edge_pixel)
`ifdef SOBEL_WIN_TIMEOUT_EN
    , .sobel_err(sobel_err)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // sobel stub: done stub_lat cycles after sobel_en rises (0 = same cycle)
  int   stub_cnt = 0;
  int   stub_lat = 1;
  logic stub_on  = 1'b1;
  always @(posedge clk) stub_cnt <= sobel_en ? stub_cnt + 1 : 0;
  assign sobel_done = sobel_en && stub_on && (stub_cnt == stub_lat);

  // monitor: accept count, captured windows, edge results, backpressure violations
  int          acc = 0;
  logic [71:0] reqs[$];
  int          req_acc[$];
  logic        edges[$];
  int          bp_viol = 0;
  logic        en_q = 1'b0;
  always @(posedge clk) begin
    if (rst) acc <= 0;
    else if (pixel_valid && pixel_ready) acc <= acc + 1;
  end
  always @(negedge clk) begin
    if (rst) begin
      reqs.delete();
      req_acc.delete();
      edges.delete();
      bp_viol <= 0;
    end else begin
      if (sobel_en && !en_q) begin
        reqs.push_back(comp_matrix);
        req_acc.push_back(acc);
      end
      if (edge_valid) edges.push_back(edge_pixel);
      if (sobel_en && pixel_ready) bp_viol <= bp_viol + 1;
    end
    en_q <= sobel_en;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic fs);
    int g;
    pixel_in    = p;
    frame_start = fs;
    pixel_valid = 1'b1;
    g = 0;
    while (!pixel_ready && g < 100) begin
      step();
      g++;
    end
    if (g >= 100) chk("ready_timeout", pixel_ready, 1);
    step();
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; pixel_valid = 1'b1; pixel_in = 8'h55; frame_start = 1'b1;
    step();
    step();
    rst = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0;
    step();
  endtask

  // rows top..bottom, each left..right
  function automatic logic [71:0] w9(input int a0, a1, a2, b0, b1, b2, c0, c1, c2);
    return {8'(c2), 8'(c1), 8'(c0), 8'(b2), 8'(b1), 8'(b0), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    // reset with pixel_valid held high
    rst = 1'b1; pixel_valid = 1'b1; pixel_in = 8'h55;
    step();
    step();
    chk("rst_ready", pixel_ready, 1);
    chk("rst_en", sobel_en, 0);
    chk("rst_edge_valid", edge_valid, 0);
    chk("rst_matrix", comp_matrix, 0);
    chk("rst_edge_pixel", edge_pixel, 0);
    rst = 1'b0; pixel_valid = 1'b0;
    step();
    chk("rst_nothing_consumed", acc, 0);

    // constant 1s, stub done after 2 cycles returning 1
    stub_lat = 1; output_pixel = 1'b1;
    for (int i = 0; i < 12; i++) send(8'd1, i == 0);
    idle(10);
    chk("ones_nreq", reqs.size(), 2);
    chk("ones_first_req_acc", req_acc[0], 11);
    chk("ones_win0", reqs[0], 72'h01_0101_0101_0101_0101);
    chk("ones_win1", reqs[1], 72'h01_0101_0101_0101_0101);
    chk("ones_nedge", edges.size(), 2);
    chk("ones_edge0", edges[0], 1);
    chk("ones_edge1", edges[1], 1);

    // ramp 0..15 with valid held high, same-cycle done returning 0
    do_reset();
    stub_lat = 0; output_pixel = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), i == 0);
    idle(6);
    chk("ramp_nreq", reqs.size(), 4);
    chk("ramp_acc0", req_acc[0], 11);
    chk("ramp_acc1", req_acc[1], 12);
    chk("ramp_acc2_no_wrap_window", req_acc[2], 15);
    chk("ramp_acc3", req_acc[3], 16);
    chk("ramp_win0", reqs[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("ramp_win1", reqs[1], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    chk("ramp_win2", reqs[2], w9(4, 5, 6, 8, 9, 10, 12, 13, 14));
    chk("ramp_win3", reqs[3], w9(5, 6, 7, 9, 10, 11, 13, 14, 15));
    chk("ramp_backpressure", bp_viol, 0);
    chk("ramp_nedge", edges.size(), 4);
    chk("ramp_edge_val", edges[3], 0);
    chk("ramp_edge_hold", edge_pixel, 0);

    // frame_start on pixel 6 of a 4-wide frame restarts the window count
    do_reset();
    stub_lat = 1; output_pixel = 1'b1;
    for (int i = 0; i < 6; i++) send(8'(100 + i), i == 0);
    for (int i = 0; i < 12; i++) send(8'(i), i == 0);
    idle(8);
    chk("fs_nreq", reqs.size(), 2);
    chk("fs_first_req_acc", req_acc[0], 17);
    chk("fs_win0", reqs[0], w9(0, 1, 2, 4, 5, 6, 8, 9, 10));
    chk("fs_win1", reqs[1], w9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    // stub never answers
    do_reset();
    stub_on = 1'b0;
    for (int i = 0; i < 11; i++) send(8'(i), i == 0);
    pixel_valid = 1'b0;
    chk("hang_en_raised", sobel_en, 1);
    hi = 0;
`ifdef SOBEL_WIN_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      if (sobel_en) hi++;
      step();
    end
    chk("tmo_en_cycles", hi, 16);
    chk("tmo_err_set", sobel_err, 1);
    chk("tmo_ready", pixel_ready, 1);
    chk("tmo_no_edge", edges.size(), 0);
    send(8'd7, 1'b1);
    idle(2);
    chk("tmo_err_cleared", sobel_err, 0);
`else
    for (int i = 0; i < 100; i++) begin
      if (sobel_en) hi++;
      step();
    end
    chk("hang_en_cycles", hi, 100);
    chk("hang_ready_low", pixel_ready, 0);
    chk("hang_no_edge", edges.size(), 0);
`endif
    stub_on = 1'b1;
    do_reset();
    chk("final_rst_en", sobel_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming front end for the `sobel` edge unit. It accepts a raster-order 8-bit grayscale pixel stream and buffers two image lines. It assembles each complete 3x3 neighbourhood into `comp_matrix`, then drives `sobel_en` and holds the window until `sobel_done` returns. It captures `output_pixel` as one edge-map bit per interior pixel, and sits between the pixel source and `sobel`.

## Interface
- `IMG_WIDTH`, 16: pixels per image row; legal range 3..1024.
- `PIX_W`, 8: pixel width in bits; must match `sobel`.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_in`  in  PIX_W  incoming pixel.
- `pixel_valid`  in  1  `pixel_in` is valid.
- `frame_start`  in  1  qualifies the accepted pixel as image (row 0, col 0).
- `pixel_ready`  out  1  block can accept a pixel this cycle.
- `sobel_en`  out  1  request to `sobel`; `comp_matrix` is valid and stable while high.
- `comp_matrix`  out  [2:0][2:0][PIX_W-1:0]  window; [r][c], r=0 top (oldest row), c=0 left (oldest column), [2][2] newest pixel.
- `sobel_done`  in  1  `sobel` result is valid.
- `output_pixel`  in  1  `sobel` edge decision.
- `edge_valid`  out  1  one-cycle pulse: `edge_pixel` is valid.
- `edge_pixel`  out  1  captured edge bit for window centre (row-1, col-1).
- `sobel_err`  out  1  sticky timeout flag; exists only with `SOBEL_WIN_TIMEOUT_EN`.

## Operation
- Accept condition: `pixel_valid & pixel_ready`. A pixel is never consumed otherwise.
- Two line buffers, each `IMG_WIDTH` deep, shift on accept:
  - LB0 holds the previous row.
  - LB1 holds the row before that.
- On accept, all three window rows shift left one column, and the new column enters at c=2:
  - [0][2] gets the LB1 output.
  - [1][2] gets the LB0 output.
  - [2][2] gets `pixel_in`.
- The window shifts across row wraps. Spliced windows are suppressed by the validity rule below.
- Counters:
  - `col` runs 0..IMG_WIDTH-1 and wraps to 0.
  - On wrap, `rows` increments and saturates at 2.
  - An accept with `frame_start=1` treats the pixel as col 0, row 0.
  - Line buffer contents are not cleared on `frame_start`.
- Window complete when the accepted pixel has `rows==2` and `col>=2`.
- FSM states:
  - RUN: `pixel_ready=1`, `sobel_en=0`. An accept that completes a window goes to ISSUE.
  - ISSUE: `pixel_ready=0`, `sobel_en=1`, `comp_matrix` frozen. When `sobel_done` is sampled 1: register `edge_pixel<=output_pixel`, pulse `edge_valid`, go to RUN.
- Non-complete accepts stay in RUN with no request.
- `sobel_done` in RUN is ignored.
- `frame_start` without an accept has no effect.
- Reset mid-operation: return to RUN and zero all state, including any pending request. No `edge_valid` is produced for the aborted window.

## Timing
- Reset values:
  - `pixel_ready=1`, `sobel_en=0`, `comp_matrix=0`, `edge_valid=0`, `edge_pixel=0`, `sobel_err=0`.
  - Counters, line buffers and FSM are cleared; FSM is in RUN.
- Window-completing accept at edge N: `sobel_en=1` and the new `comp_matrix` are visible from cycle N+1.
- `sobel_done` sampled at edge M:
  - `edge_valid=1` for exactly cycle M+1.
  - `sobel_en=0` and `pixel_ready=1` from M+1.
- Minimum per-window turnaround: 2 cycles, for a same-cycle `sobel_done`.
- Throughput: 1 pixel/cycle outside ISSUE.
- `edge_pixel` holds its value until the next capture.

## Configuration
- `SOBEL_WIN_TIMEOUT_EN` defined:
  - A 4-bit counter runs in ISSUE.
  - If 16 consecutive ISSUE cycles pass without `sobel_done`, drop `sobel_en`, return to RUN and set `sobel_err=1`. No `edge_valid` pulse is produced.
  - `sobel_err` clears on `rst` or on an accept with `frame_start=1`.
- Not defined: no counter, no `sobel_err` port, and ISSUE waits indefinitely.

## Test plan
- Reset: assert `rst` 2 cycles with `pixel_valid=1`. Required: `pixel_ready=1`, `sobel_en=0`, `edge_valid=0`, `comp_matrix=0`, nothing consumed.
- IMG_WIDTH=4, 12 pixels all value 1, `sobel` stub returning done after 2 cycles with `output_pixel=1`:
  - No `sobel_en` before the 11th accept.
  - Two requests total, each with `comp_matrix` all 1s.
  - Two `edge_valid` pulses with `edge_pixel=1`.
- IMG_WIDTH=4, ramp 0..11:
  - First window {{0,1,2},{4,5,6},{8,9,10}}.
  - Second window {{1,2,3},{5,6,7},{9,10,11}}.
  - No window at the row-3 wrap.
- Backpressure: hold `pixel_valid=1` with a ramp through ISSUE. Required: `pixel_ready=0` during ISSUE, and the post-release sequence continues without loss or duplication; check the following window contents.
- Mid-frame `frame_start` on pixel 6 of a 4-wide frame: no `sobel_en` until 11 further accepts. First new window equals the new frame's ramp.
- `SOBEL_WIN_TIMEOUT_EN` on, stub never asserts done: `sobel_en` falls after 16 cycles, `sobel_err=1`, no `edge_valid`. A `frame_start` accept clears `sobel_err`. With the macro off, `sobel_en` stays high for 100 cycles.
